// File: rtl/result_pager_pkg.sv
// Shared types and constants for the result pager: FSM states, page indices, status-byte layout.
// STATUS_PAGE_EN adds the SHOW_STAT state.
package result_pager_pkg;

`ifdef STATUS_PAGE_EN
  typedef enum logic [1:0] {IDLE, SHOW_LO, SHOW_HI, SHOW_STAT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHOW_LO, SHOW_HI} state_t;
`endif

  localparam logic [1:0] PAGE_LO   = 2'd0;
  localparam logic [1:0] PAGE_HI   = 2'd1;
  localparam logic [1:0] PAGE_STAT = 2'd2;

  localparam int STAT_ONE_BIT   = 0;
  localparam int STAT_OVF_BIT   = 1;
  localparam int STAT_FLAGS_LSB = 4;

  // Status byte: {flags[3:0], 2'b00, overflow, 1'b1}
  function automatic logic [7:0] status_byte(input logic [3:0] flags, input logic ovf);
    logic [7:0] b;
    b = '0;
    b[STAT_FLAGS_LSB +: 4] = flags;
    b[STAT_OVF_BIT]        = ovf;
    b[STAT_ONE_BIT]        = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Two-flop synchronizer plus previous-value flop; emits a one-cycle pulse on a rising level.
module btn_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level_in,
  output logic edge_out
);

  logic sync0, sync1, prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync0 <= level_in;
      sync1 <= sync0;
      prev  <= sync1;
    end
  end

  assign edge_out = sync1 & ~prev;

endmodule

// File: rtl/result_pager.sv
// Captures a CPU result and pages it byte-by-byte onto an LED bank, one button press per page.
// Build option: define STATUS_PAGE_EN to add a status page after the high byte.
module result_pager
  import result_pager_pkg::*;
#(
  parameter logic [7:0] LED_IDLE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  input  logic [15:0] res_data,
  input  logic [3:0]  res_flags,
  output logic        res_ready,
  input  logic        btn_level,
  output logic [7:0]  led_out,
  output logic [1:0]  page_idx,
  output logic        busy
);

  logic        press;
  state_t      state;
  logic [15:0] data_q;
  logic [3:0]  flags_q;

  btn_edge_det u_btn (
    .clk      (clk),
    .rst_n    (rst_n),
    .level_in (btn_level),
    .edge_out (press)
  );

`ifdef STATUS_PAGE_EN
  logic overflow_seen;

  // Sticky: the core tried to hand over a result we could not take.
  always_ff @(posedge clk) begin
    if (!rst_n)                overflow_seen <= 1'b0;
    else if (busy && res_valid) overflow_seen <= 1'b1;
  end
`else
  logic unused_flags;
  assign unused_flags = ^flags_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      flags_q   <= '0;
      led_out   <= LED_IDLE;
      page_idx  <= PAGE_LO;
      busy      <= 1'b0;
      res_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // A press landing on the capture edge is simply not looked at here.
          if (res_valid) begin
            data_q    <= res_data;
            flags_q   <= res_flags;
            state     <= SHOW_LO;
            led_out   <= res_data[7:0];
            page_idx  <= PAGE_LO;
            busy      <= 1'b1;
            res_ready <= 1'b0;
          end
        end
        SHOW_LO: begin
          if (press) begin
            state    <= SHOW_HI;
            led_out  <= data_q[15:8];
            page_idx <= PAGE_HI;
          end
        end
        SHOW_HI: begin
          if (press) begin
`ifdef STATUS_PAGE_EN
            state    <= SHOW_STAT;
            led_out  <= status_byte(flags_q, overflow_seen | res_valid);
            page_idx <= PAGE_STAT;
`else
            state     <= IDLE;
            led_out   <= LED_IDLE;
            page_idx  <= PAGE_LO;
            busy      <= 1'b0;
            res_ready <= 1'b1;
`endif
          end
        end
`ifdef STATUS_PAGE_EN
        SHOW_STAT: begin
          if (press) begin
            state     <= IDLE;
            led_out   <= LED_IDLE;
            page_idx  <= PAGE_LO;
            busy      <= 1'b0;
            res_ready <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          led_out   <= LED_IDLE;
          page_idx  <= PAGE_LO;
          busy      <= 1'b0;
          res_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
